fetch_sequencer: RTL and testbench

Control FSM that sequences instruction fetch for the simple CPU: it owns the program-counter register, drives the RAM read port, latches the fetched instruction and hands it to the execute stage over a start/done handshake. It sits between the instruction RAM and the execute unit and decides the next fetch address (increment, branch, or halt) once each instruction completes.

---
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control FSM for the simple CPU.
// Owns the program counter. Reads the instruction RAM (1-cycle synchronous latency) and
// latches the word into instr. Hands instr to the execute unit with a one-cycle exec_start
// pulse, then picks the next PC (increment, branch or halt) when exec_done arrives.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              begin execution at address 0 (honoured in IDLE/HALT only)
//   ram_addr/ram_rd_en RAM read port (ram_addr = pc)
//   ram_rdata          RAM read data, valid in LOAD
//   instr              latched instruction register
//   exec_start         one-cycle pulse in EXEC
//   exec_done          execute finished (sampled in WAIT only), qualifies:
//   branch_taken/branch_target/halt_req  next-PC decision inputs
//   pc, running, halted, fault           status outputs
//
// Optional feature: define SEQ_WATCHDOG_EN to halt with fault=1 after WDOG_CYCLES
// consecutive WAIT cycles without exec_done. Without it, fault is tied to 0.
module fetch_sequencer #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_rd_en,
  input  logic [INSTR_W-1:0] ram_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               exec_start,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  pc,
  output logic               running,
  output logic               halted,
  output logic               fault
);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StExec, StWait, StHalt} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             fault_q, fault_d;
  logic             wdog_expired;

  // True in the WDOG_CYCLES-th consecutive WAIT cycle without exec_done.
  assign wdog_expired = (wdog_q == WdogW'(WDOG_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef SEQ_WATCHDOG_EN
    wdog_d  = wdog_q;
    fault_d = fault_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        instr_d = ram_rdata;
        state_d = StExec;
      end
      StExec: begin
        state_d = StWait;
`ifdef SEQ_WATCHDOG_EN
        wdog_d  = '0;
`endif
      end
      StWait: begin
        if (exec_done) begin
          // Halt has priority over a simultaneous branch.
          if (halt_req) begin
            state_d = StHalt;
          end else if (branch_taken) begin
            pc_d    = branch_target;
            state_d = StFetch;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wdog_expired) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
`endif
      end
      StHalt: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
`ifdef SEQ_WATCHDOG_EN
          fault_d = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
`ifdef SEQ_WATCHDOG_EN
      wdog_q  <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef SEQ_WATCHDOG_EN
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
`endif
    end
  end

  // Moore outputs from registered state.
  assign pc         = pc_q;
  assign ram_addr   = pc_q;
  assign instr      = instr_q;
  assign ram_rd_en  = (state_q == StFetch);
  assign exec_start = (state_q == StExec);
  assign running    = (state_q == StFetch) || (state_q == StLoad) ||
                      (state_q == StExec)  || (state_q == StWait);
  assign halted     = (state_q == StHalt);
`ifdef SEQ_WATCHDOG_EN
  assign fault      = fault_q;
`else
  assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer. Inputs are driven and outputs sampled
// 1 time unit after the rising edge. A behavioural synchronous RAM supplies instructions.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  ram_addr;
  logic        ram_rd_en;
  logic [15:0] ram_rdata;
  logic [15:0] instr;
  logic        exec_start;
  logic        exec_done;
  logic        branch_taken;
  logic [5:0]  branch_target;
  logic        halt_req;
  logic [5:0]  pc;
  logic        running;
  logic        halted;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W      (6),
    .INSTR_W     (16),
    .WDOG_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ram_addr      (ram_addr),
    .ram_rd_en     (ram_rd_en),
    .ram_rdata     (ram_rdata),
    .instr         (instr),
    .exec_start    (exec_start),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .pc            (pc),
    .running       (running),
    .halted        (halted),
    .fault         (fault)
  );

  // RAM contents: distinct word per address.
  function automatic logic [15:0] mem_word(input logic [5:0] a);
    return 16'hC000 | (16'(a) * 16'd37);
  endfunction

  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem_word(ram_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH; runs one instruction and leaves the DUT in the cycle after WAIT.
  task automatic fetch_cycle(input logic [5:0] addr, input logic br, input logic [5:0] tgt,
                             input logic hr);
    check_eq("fetch_rd_en", 32'(ram_rd_en), 32'd1);
    check_eq("fetch_addr", 32'(ram_addr), 32'(addr));
    check_eq("fetch_pc", 32'(pc), 32'(addr));
    check_eq("fetch_running", 32'(running), 32'd1);
    tick();
    check_eq("load_rd_en", 32'(ram_rd_en), 32'd0);
    check_eq("load_xs", 32'(exec_start), 32'd0);
    tick();
    check_eq("exec_xs", 32'(exec_start), 32'd1);
    check_eq("exec_instr", 32'(instr), 32'(mem_word(addr)));
    // Raised already in EXEC, where it must be ignored; counted only in WAIT.
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    halt_req      = hr;
    tick();
    check_eq("wait_xs", 32'(exec_start), 32'd0);
    check_eq("wait_running", 32'(running), 32'd1);
    tick();
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 6'h3f;
    halt_req      = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 6'h3f;
    halt_req      = 1'b0;
    tick();
    tick();
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_instr", 32'(instr), 32'd0);
    check_eq("rst_rd_en", 32'(ram_rd_en), 32'd0);
    check_eq("rst_xs", 32'(exec_start), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("idle_running", 32'(running), 32'd0);

    // Sequential fetch 0..3, branch from 3 to 0x10.
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch_cycle(6'd0, 1'b0, 6'd0, 1'b0);
    fetch_cycle(6'd1, 1'b0, 6'd0, 1'b0);
    fetch_cycle(6'd2, 1'b0, 6'd0, 1'b0);
    fetch_cycle(6'd3, 1'b1, 6'h10, 1'b0);
    fetch_cycle(6'h10, 1'b1, 6'd63, 1'b0);

    // Wrap 63 -> 0 while start is held high; start must not disturb the sequence.
    start = 1'b1;
    fetch_cycle(6'd63, 1'b0, 6'd0, 1'b0);
    fetch_cycle(6'd0, 1'b0, 6'd0, 1'b0);
    start = 1'b0;
    fetch_cycle(6'd1, 1'b1, 6'd5, 1'b0);

    // Halt beats branch.
    fetch_cycle(6'd5, 1'b1, 6'h20, 1'b1);
    check_eq("halt_halted", 32'(halted), 32'd1);
    check_eq("halt_pc", 32'(pc), 32'd5);
    check_eq("halt_running", 32'(running), 32'd0);
    check_eq("halt_fault", 32'(fault), 32'd0);
    check_eq("halt_instr", 32'(instr), 32'(mem_word(6'd5)));
    for (int i = 0; i < 20; i++) begin
      check_eq("halt_rd_en", 32'(ram_rd_en), 32'd0);
      check_eq("halt_xs", 32'(exec_start), 32'd0);
      tick();
    end
    check_eq("halt_hold_pc", 32'(pc), 32'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_halted", 32'(halted), 32'd0);
    fetch_cycle(6'd0, 1'b1, 6'd7, 1'b0);

    // Reset in WAIT at pc=7.
    check_eq("pre_rst_pc", 32'(pc), 32'd7);
    tick();
    tick();
    tick();
    check_eq("pre_rst_wait", 32'(running), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mrst_pc", 32'(pc), 32'd0);
    check_eq("mrst_instr", 32'(instr), 32'd0);
    check_eq("mrst_running", 32'(running), 32'd0);
    check_eq("mrst_halted", 32'(halted), 32'd0);
    check_eq("mrst_rd_en", 32'(ram_rd_en), 32'd0);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("mrst_idle_rd_en", 32'(ram_rd_en), 32'd0);
      check_eq("mrst_idle_running", 32'(running), 32'd0);
      tick();
    end

    // Execute unit never answers.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check_eq("wd_wait1", 32'(running), 32'd1);
`ifdef SEQ_WATCHDOG_EN
    repeat (7) tick();
    check_eq("wd_wait8_running", 32'(running), 32'd1);
    check_eq("wd_wait8_fault", 32'(fault), 32'd0);
    tick();
    check_eq("wd_halted", 32'(halted), 32'd1);
    check_eq("wd_fault", 32'(fault), 32'd1);
    check_eq("wd_pc", 32'(pc), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("wd_clr_fault", 32'(fault), 32'd0);
    check_eq("wd_clr_halted", 32'(halted), 32'd0);
    check_eq("wd_clr_rd_en", 32'(ram_rd_en), 32'd1);
`else
    repeat (100) tick();
    check_eq("nowd_running", 32'(running), 32'd1);
    check_eq("nowd_halted", 32'(halted), 32'd0);
    check_eq("nowd_fault", 32'(fault), 32'd0);
    check_eq("nowd_rd_en", 32'(ram_rd_en), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
